// File: rtl/ls_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ls_sequencer
// Description : Moore control sequencer for a load/store datapath. Runs the
//               instruction fetch (T0..T2), the base+offset address
//               calculation (T3..T4) and the ld / ldi / st execution steps
//               (T5..T7). It stretches memory accesses with wait states and
//               raises a sticky fault when memory never answers.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clock     in   1  rising-edge clock
//   clear     in   1  asynchronous active-low reset
//   start     in   1  begin one instruction (sampled in IDLE only)
//   opcode    in   5  IR[31:27], valid from T3 onward
//   mem_ready in   1  memory access completes this cycle
//   fault_ack in   1  releases FAULT back to IDLE
//   ctrl      out 16  datapath strobes
//   ALUCode   out  5  ALU operation select
//   busy      out  1  high outside IDLE and FAULT
//   done      out  1  one-cycle completion pulse
//   illegal   out  1  qualifies done: opcode was not recognised
//   fault     out  1  memory timeout, held until fault_ack
//   state     out  4  current state encoding (debug)
// ============================================================================
module ls_sequencer #(
    parameter logic [4:0] ALU_INCPC = 5'b11111,
    parameter logic [4:0] ALU_ADD   = 5'b00011,
    parameter logic [4:0] OPC_LD    = 5'b00000,
    parameter logic [4:0] OPC_LDI   = 5'b00001,
    parameter logic [4:0] OPC_ST    = 5'b00010,
    parameter int         MAX_WAIT  = 15
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        start,
    input  logic [4:0]  opcode,
    input  logic        mem_ready,
    input  logic        fault_ack,
    output logic [15:0] ctrl,
    output logic [4:0]  ALUCode,
    output logic        busy,
    output logic        done,
    output logic        illegal,
    output logic        fault,
    output logic [3:0]  state
);

    // ctrl bit positions
    localparam int c_PCOUT    = 0;
    localparam int c_MARIN    = 1;
    localparam int c_ZIN      = 2;
    localparam int c_ZLOOUT   = 3;
    localparam int c_PCIN     = 4;
    localparam int c_MEMREAD  = 5;
    localparam int c_MDRIN    = 6;
    localparam int c_MDROUT   = 7;
    localparam int c_IRIN     = 8;
    localparam int c_GRB      = 9;
    localparam int c_ROUT     = 10;
    localparam int c_YIN      = 11;
    localparam int c_COUT     = 12;
    localparam int c_MEMWRITE = 13;
    localparam int c_GRA      = 14;
    localparam int c_RIN      = 15;

    localparam logic [7:0] c_MAX_WAIT = 8'(MAX_WAIT);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_T0    = 4'd1,
        S_T1    = 4'd2,
        S_T2    = 4'd3,
        S_T3    = 4'd4,
        S_T4    = 4'd5,
        S_T5    = 4'd6,
        S_T6    = 4'd7,
        S_T7    = 4'd8,
        S_DONE  = 4'd9,
        S_FAULT = 4'd10
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_wait;
    logic [4:0]  r_op;
    logic        w_known;
    logic        w_wait_max;
    logic        w_in_wait;

    // Strobes for a given state. T5..T7 depend on the instruction, which is
    // always taken from the opcode latched at the end of T3.
    function automatic logic [15:0] f_ctrl(input state_t s, input logic [4:0] op);
        logic [15:0] v;
        v = '0;
        case (s)
            S_T0: begin
                v[c_PCOUT] = 1'b1; v[c_MARIN] = 1'b1; v[c_ZIN] = 1'b1;
            end
            S_T1: begin
                v[c_ZLOOUT] = 1'b1; v[c_PCIN] = 1'b1;
                v[c_MEMREAD] = 1'b1; v[c_MDRIN] = 1'b1;
            end
            S_T2: begin
                v[c_MDROUT] = 1'b1; v[c_IRIN] = 1'b1;
            end
            S_T3: begin
                v[c_GRB] = 1'b1; v[c_ROUT] = 1'b1; v[c_YIN] = 1'b1;
            end
            S_T4: begin
                v[c_COUT] = 1'b1; v[c_ZIN] = 1'b1;
            end
            S_T5: begin
                v[c_ZLOOUT] = 1'b1;
                if (op == OPC_LDI) begin
                    v[c_GRA] = 1'b1; v[c_RIN] = 1'b1;
                end else begin
                    v[c_MARIN] = 1'b1;
                end
            end
            S_T6: begin
                if (op == OPC_LD) begin
                    v[c_MEMREAD] = 1'b1; v[c_MDRIN] = 1'b1;
                end else begin
                    v[c_MEMWRITE] = 1'b1; v[c_GRA] = 1'b1; v[c_ROUT] = 1'b1;
                end
            end
            S_T7: begin
                v[c_MDROUT] = 1'b1; v[c_GRA] = 1'b1; v[c_RIN] = 1'b1;
            end
            default: v = '0;
        endcase
        return v;
    endfunction

    function automatic logic [4:0] f_alu(input state_t s);
        logic [4:0] a;
        case (s)
            S_T0:    a = ALU_INCPC;
            S_T4:    a = ALU_ADD;
            default: a = 5'b00000;
        endcase
        return a;
    endfunction

    assign w_known    = (opcode == OPC_LD) || (opcode == OPC_LDI) || (opcode == OPC_ST);
    assign w_wait_max = (r_wait == c_MAX_WAIT);
    assign w_in_wait  = (r_state == S_T1) || (r_state == S_T6);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_T0;
            S_T0:    w_next = S_T1;
            S_T1: begin
                if (mem_ready)       w_next = S_T2;
                else if (w_wait_max) w_next = S_FAULT;
            end
            S_T2:    w_next = S_T3;
            S_T3:    w_next = w_known ? S_T4 : S_DONE;
            S_T4:    w_next = S_T5;
            S_T5:    w_next = (r_op == OPC_LDI) ? S_DONE : S_T6;
            S_T6: begin
                if (mem_ready)       w_next = (r_op == OPC_LD) ? S_T7 : S_DONE;
                else if (w_wait_max) w_next = S_FAULT;
            end
            S_T7:    w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            S_FAULT: if (fault_ack) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so that each one is a pure
    // function of the state the machine is in during that cycle.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_state <= S_IDLE;
            r_wait  <= 8'd0;
            r_op    <= 5'd0;
            ctrl    <= 16'd0;
            ALUCode <= 5'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            illegal <= 1'b0;
            fault   <= 1'b0;
        end else begin
            r_state <= w_next;

            if (r_state == S_T3) r_op <= opcode;

            // Counter restarts on entering a wait-capable state and counts
            // cycles spent there without mem_ready.
            if ((w_next != r_state) && ((w_next == S_T1) || (w_next == S_T6)))
                r_wait <= 8'd0;
            else if (w_in_wait && !mem_ready)
                r_wait <= r_wait + 8'd1;

            ctrl    <= f_ctrl(w_next, r_op);
            ALUCode <= f_alu(w_next);
            busy    <= (w_next != S_IDLE) && (w_next != S_FAULT);
            done    <= (w_next == S_DONE);
            illegal <= (r_state == S_T3) && !w_known;
            fault   <= (w_next == S_FAULT);
        end
    end

    assign state = r_state;

endmodule
`default_nettype wire
